// File: rtl/key_pkg.sv
// Shared definitions for the keypad event buffer: capture FSM encoding,
// CPU register addresses and the accepted key-code range.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPT    = 2'd1,
    ST_CLR     = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  localparam logic       ADDR_DATA   = 1'b0;
  localparam logic       ADDR_STATUS = 1'b1;
  localparam logic [3:0] KEY_MIN     = 4'd1;
  localparam logic [3:0] KEY_MAX     = 4'd8;

  // Width of the entry count as shown in the STATUS register.
  localparam int CNT_W = 5;

  function automatic logic key_valid(input logic [3:0] code);
    return (code >= KEY_MIN) && (code <= KEY_MAX);
  endfunction

endpackage

// File: rtl/key_event_buf_if.sv
// CPU-side register bus of the keypad event buffer.
interface key_event_buf_if;
  logic       cs_i;
  logic       rd_i;
  logic       addr_i;
  logic [7:0] dat_o;
  logic       int_o;

  modport master (output cs_i, output rd_i, output addr_i, input dat_o, input int_o);
  modport slave  (input cs_i, input rd_i, input addr_i, output dat_o, output int_o);
endinterface

// File: rtl/key_fifo.sv
// Synchronous key-code FIFO; a push into a full FIFO is taken only when a
// pop happens on the same edge.
module key_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [3:0]       din_i,
  output logic [3:0]       dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]       mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_r == CNT_W'(DEPTH));
  assign empty_o = (count_r == {CNT_W{1'b0}});
  assign pop_s   = pop_i & ~empty_o;
  assign push_s  = push_i & (~full_o | pop_s);
  assign dout_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din_i;
    end
  end

endmodule

// File: rtl/key_event_buf.sv
// Keypad event buffer: captures scanner key codes into a FIFO, pulses a clear
// request back to the scanner and exposes DATA/STATUS registers to the CPU.
module key_event_buf
  import key_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CLR_CYC = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      key_i,
  input  logic            sta_i,
  output logic            clr_o,
  key_event_buf_if.slave  bus
);

  localparam int CW = $clog2(CLR_CYC);

  state_t           state_r, state_nxt_s;
  logic             sta_meta_r, sta_sync_r, sta_prev_r;
  logic [CW-1:0]    clr_cnt_r;
  logic             ovf_r, ovf_nxt_s;
  logic             clr_r, int_r;
  logic [7:0]       dat_r, dat_nxt_s;
  logic [3:0]       fifo_dout_s;
  logic             full_s, empty_s;
  logic [CNT_W-1:0] count_s, count_nxt_s;
  logic             rise_s, rd_data_s, rd_stat_s, capt_s, push_s, pop_s, ovf_set_s;

  assign rise_s    = sta_sync_r & ~sta_prev_r;
  assign rd_data_s = bus.cs_i & bus.rd_i & (bus.addr_i == ADDR_DATA);
  assign rd_stat_s = bus.cs_i & bus.rd_i & (bus.addr_i == ADDR_STATUS);
  assign capt_s    = (state_r == ST_CAPT) & key_valid(key_i);
  assign pop_s     = rd_data_s & ~empty_s;
  assign push_s    = capt_s & (~full_s | pop_s);
  assign ovf_set_s = capt_s & full_s & ~pop_s;
  // int_o is registered from post-edge occupancy so it drops on the read edge itself.
  assign count_nxt_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (key_i),
    .dout_o  (fifo_dout_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // Capture FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (rise_s) state_nxt_s = ST_CAPT; else state_nxt_s = ST_IDLE;
      ST_CAPT:    state_nxt_s = ST_CLR;
      ST_CLR:     if (clr_cnt_r == CW'(CLR_CYC - 1)) state_nxt_s = ST_WAIT_LO;
                  else state_nxt_s = ST_CLR;
      ST_WAIT_LO: if (!sta_sync_r) state_nxt_s = ST_IDLE; else state_nxt_s = ST_WAIT_LO;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Overflow flag and read-data selection; a capture overflow beats a STATUS clear.
  always_comb begin
    ovf_nxt_s = ovf_r;
    dat_nxt_s = dat_r;
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (rd_stat_s) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
    if (rd_data_s) begin
      if (empty_s) dat_nxt_s = 8'h00;
      else         dat_nxt_s = {4'b0000, fifo_dout_s};
    end else if (rd_stat_s) begin
      dat_nxt_s = {ovf_r, 2'b00, count_s};
    end else begin
      dat_nxt_s = dat_r;
    end
  end

  // State, synchroniser, CLR counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      sta_meta_r <= 1'b0;
      sta_sync_r <= 1'b0;
      sta_prev_r <= 1'b0;
      clr_cnt_r  <= {CW{1'b0}};
      ovf_r      <= 1'b0;
      clr_r      <= 1'b0;
      dat_r      <= 8'h00;
      int_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      sta_meta_r <= sta_i;
      sta_sync_r <= sta_meta_r;
      sta_prev_r <= sta_sync_r;
      if (state_r == ST_CLR) clr_cnt_r <= clr_cnt_r + CW'(1);
      else                   clr_cnt_r <= {CW{1'b0}};
      ovf_r      <= ovf_nxt_s;
      clr_r      <= (state_nxt_s == ST_CLR);
      dat_r      <= dat_nxt_s;
      int_r      <= (count_nxt_s != {CNT_W{1'b0}}) | ovf_nxt_s;
    end
  end

  assign clr_o     = clr_r;
  assign bus.dat_o = dat_r;
  assign bus.int_o = int_r;

endmodule

// File: tb/tb_key_event_buf.sv
// Scoreboard bench for key_event_buf: a queue-based reference model predicts
// read data, a negedge monitor compares every registered read result.
module tb_key_event_buf;
  localparam int DEPTH   = 4;
  localparam int CLR_CYC = 256;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] key_i = 4'd0;
  logic       sta_i = 1'b0;
  logic       clr_o;

  key_event_buf_if bus ();

  key_event_buf #(.DEPTH(DEPTH), .CLR_CYC(CLR_CYC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .key_i (key_i),
    .sta_i (sta_i),
    .clr_o (clr_o),
    .bus   (bus)
  );

  always #10 clk_i = ~clk_i;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] mq [$];
  logic       m_ovf = 1'b0;
  logic [7:0] exp_q [$];
  logic       rd_seen = 1'b0;
  logic [7:0] last_dat = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk_i) rd_seen <= bus.cs_i & bus.rd_i & ~rst_i;

  // Monitor: every completed read is compared against the next predicted value.
  always @(negedge clk_i) begin
    if (rst_i) begin
      last_dat = 8'h00;
    end else if (rd_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        chk("dat_o", {24'd0, bus.dat_o}, {24'd0, exp_q.pop_front()});
      end
      last_dat = bus.dat_o;
    end else begin
      chk("dat_hold", {24'd0, bus.dat_o}, {24'd0, last_dat});
    end
  end

  function automatic void model_capture(input logic [3:0] code);
    if (code >= 4'd1 && code <= 4'd8) begin
      if (mq.size() < DEPTH) mq.push_back(code);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic bus_read(input logic a);
    logic [7:0] e;
    @(negedge clk_i);
    bus.cs_i = 1'b1; bus.rd_i = 1'b1; bus.addr_i = a;
    if (a == 1'b0) begin
      if (mq.size() > 0) e = {4'h0, mq.pop_front()};
      else e = 8'h00;
    end else begin
      e = {m_ovf, 2'b00, 5'(mq.size())};
      m_ovf = 1'b0;
    end
    exp_q.push_back(e);
    @(negedge clk_i);
    bus.cs_i = 1'b0; bus.rd_i = 1'b0;
  endtask

  task automatic ignored_read(input logic a);
    @(negedge clk_i);
    bus.addr_i = a;
    if ($urandom_range(0, 1) == 0) begin bus.cs_i = 1'b0; bus.rd_i = 1'b1; end
    else begin bus.cs_i = 1'b1; bus.rd_i = 1'b0; end
    @(negedge clk_i);
    bus.cs_i = 1'b0; bus.rd_i = 1'b0;
  endtask

  task automatic check_int();
    @(negedge clk_i);
    chk("int_o", {31'd0, bus.int_o}, {31'd0, ((mq.size() != 0) || m_ovf)});
  endtask

  // One key press: sta_i high for 'hold' cycles, clr_o pulse measured.
  task automatic press(input logic [3:0] code, input int hold);
    int t; int n; bit seen; bit retrig;
    @(negedge clk_i);
    key_i = code; sta_i = 1'b1;
    t = 0; seen = 1'b0;
    while (!seen && t < 20) begin
      @(negedge clk_i); t++;
      if (clr_o) seen = 1'b1;
    end
    chk("clr_rise", {31'd0, seen}, 32'd1);
    if (seen) model_capture(code);
    n = 0;
    while (clr_o && n < 2 * CLR_CYC) begin
      n++;
      @(negedge clk_i); t++;
      if (t >= hold) sta_i = 1'b0;
    end
    chk("clr_len", n, CLR_CYC);
    retrig = 1'b0;
    while (t < hold) begin
      @(negedge clk_i); t++;
      if (clr_o) retrig = 1'b1;
    end
    chk("no_retrig", {31'd0, retrig}, 32'd0);
    sta_i = 1'b0;
    repeat (6) @(negedge clk_i);
  endtask

  initial begin
    bus.cs_i = 1'b0; bus.rd_i = 1'b0; bus.addr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_clr_o", {31'd0, clr_o}, 32'd0);
    chk("rst_dat_o", {24'd0, bus.dat_o}, 32'd0);
    chk("rst_int_o", {31'd0, bus.int_o}, 32'd0);
    #2 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single press held well past the clear pulse, then read it back.
    press(4'd5, 500);
    check_int();
    bus_read(1'b0);
    check_int();

    // Empty DATA read.
    bus_read(1'b0);
    bus_read(1'b1);

    // Five presses overflow a four-deep FIFO.
    press(4'd1, 30); press(4'd2, 30); press(4'd3, 30); press(4'd4, 30); press(4'd6, 30);
    check_int();
    bus_read(1'b1);
    for (int i = 0; i < 4; i++) bus_read(1'b0);
    bus_read(1'b1);
    check_int();

    // Key held through CLR waits in WAIT_LO; a fresh edge makes the second push.
    press(4'd7, 400);
    press(4'd8, 40);
    bus_read(1'b1);

    // Invalid codes still pulse clr_o but are not stored.
    press(4'd0, 20);
    press(4'd9, 20);
    bus_read(1'b1);
    bus_read(1'b0); bus_read(1'b0);

    // Fill, then land a DATA pop on the CAPT cycle of a new press.
    press(4'd1, 20); press(4'd2, 20); press(4'd3, 20); press(4'd4, 20);
    @(negedge clk_i);
    key_i = 4'd7; sta_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    bus.cs_i = 1'b1; bus.rd_i = 1'b1; bus.addr_i = 1'b0;
    exp_q.push_back({4'h0, mq.pop_front()});
    mq.push_back(4'd7);
    @(negedge clk_i);
    bus.cs_i = 1'b0; bus.rd_i = 1'b0;
    begin
      int w;
      w = 0;
      while (clr_o && w < 2 * CLR_CYC) begin @(negedge clk_i); w++; end
      chk("coinc_clr_end", {31'd0, clr_o}, 32'd0);
    end
    sta_i = 1'b0;
    repeat (6) @(negedge clk_i);
    bus_read(1'b1);
    for (int i = 0; i < 4; i++) bus_read(1'b0);

    // Randomised mix of presses and bus accesses.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    press(4'($urandom_range(0, 15)), int'($urandom_range(5, 300)));
        2:       bus_read(1'b0);
        3:       bus_read(1'b1);
        default: ignored_read(1'($urandom_range(0, 1)));
      endcase
      check_int();
    end

    // Reset 100 cycles into the clear pulse.
    bus_read(1'b1);
    press(4'd3, 20);
    @(negedge clk_i);
    key_i = 4'd2; sta_i = 1'b1;
    begin
      int w;
      w = 0;
      while (!clr_o && w < 20) begin @(negedge clk_i); w++; end
      chk("rst_test_clr_rise", {31'd0, clr_o}, 32'd1);
    end
    repeat (100) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midclr_clr_o", {31'd0, clr_o}, 32'd0);
    chk("midclr_int_o", {31'd0, bus.int_o}, 32'd0);
    chk("midclr_dat_o", {24'd0, bus.dat_o}, 32'd0);
    mq.delete(); m_ovf = 1'b0;
    sta_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    bus_read(1'b1);
    check_int();

    repeat (3) @(negedge clk_i);
    chk("exp_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
